mem_bus_unit: RTL and testbench
===============================

// Module: mem_bus_unit
// PURPOSE
//  Parametrised memory bus unit for the multi-cycle CPU family.
//  Arbitrates NUM_CH requesters (e.g. instruction fetch and data access) onto a single
//  readM/writeM/address/data(inout) memory port, with a configurable fixed memory latency.
//  Counts completed accesses.
//  Sits between the datapath/control unit and the external memory model in the cpu top level.
// PARAMETERS
//  WORD_SIZE  16  width of address, data, ch_addr/ch_wdata/ch_rdata slices
//  NUM_CH     2   number of requesting channels; must be >= 1
//  MEM_LAT    2   cycles readM/writeM is held per access; must be >= 1
//  CNT_W      16  width of num_access counter
// PORTS
//  clk         in     1                  clock, all state on rising edge
//  reset       in     1                  asynchronous, active-high reset
//  ch_req      in     NUM_CH             per-channel request; held until that channel's ack
//  ch_we       in     NUM_CH             per-channel write enable (1=write, 0=read)
//  ch_addr     in     NUM_CH*WORD_SIZE   per-channel address; channel i at [i*WORD_SIZE +: WORD_SIZE]
//  ch_wdata    in     NUM_CH*WORD_SIZE   per-channel write data, same slicing as ch_addr
//  ch_ack      out    NUM_CH             one-hot, one-cycle completion pulse
//  ch_rdata    out    WORD_SIZE          read data; valid only in the ack cycle of a read
//  readM       out    1                  memory read strobe
//  writeM      out    1                  memory write strobe
//  address     out    WORD_SIZE          memory address
//  data        inout  WORD_SIZE          driven only while writeM=1, otherwise high-Z
//  busy        out    1                  1 in any state other than IDLE
//  num_access  out    CNT_W              completed-access counter
// BEHAVIOUR
//  - Reset is asynchronous and active-high. It takes effect immediately, also mid-access.
//    - Outputs: readM=0, writeM=0, ch_ack=0, busy=0, num_access=0, address=0, ch_rdata=0, data=Z.
//    - State goes to IDLE and the round-robin pointer goes to 0.
//  - FSM states are IDLE, ACCESS and DONE.
//  - IDLE:
//    - If any ch_req is set, grant the first requesting channel at or after the RR pointer, then go to ACCESS.
//    - Latch the granted channel's we, addr and wdata; later changes to those inputs are ignored.
//  - ACCESS:
//    - Lasts exactly MEM_LAT cycles.
//    - readM = ~we and writeM = we; address = latched addr.
//    - For writes, data = latched wdata.
//    - For reads, data is sampled at the final ACCESS edge into ch_rdata.
//    - Then go to DONE.
//  - DONE (one cycle):
//    - ch_ack[granted] = 1; readM = writeM = 0; data = Z.
//    - num_access increments at the end of this cycle and wraps modulo 2^CNT_W.
//    - RR pointer becomes (granted+1) mod NUM_CH; next state is IDLE.
//  - Latency: request seen in IDLE at cycle 0 -> strobe in cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
//    The next grant is no earlier than cycle MEM_LAT+2.
//  - Handshake:
//    - A requester keeps req high until ack.
//    - It drops req, or presents a new request, from the cycle after ack.
//    - DONE->IDLE guarantees the acked request is not re-granted.
//  - Simultaneous requests are resolved by round-robin. No channel starves; worst-case wait is NUM_CH-1 accesses.
//  - A req dropped during ACCESS is a protocol violation. The access still completes and the ack is still issued.
//  - ch_rdata holds its value until the next read completes; it is unchanged by writes.
//  - readM and writeM are never both 1. The bus is never driven in IDLE or DONE.
//  - NUM_CH=1 degenerates to a plain requester/memory bridge with no arbitration.
// STRUCTURE
//  - Shared definitions go in header.v:
//    - WORD_SIZE define.
//    - FSM state encodings (MBU_IDLE, MBU_ACCESS, MBU_DONE).
//    - Default MEM_LAT.
//  - Sub-module rr_arbiter(NUM_CH): combinational one-hot grant from req and pointer.
//  - Everything else is in this file: FSM, latency counter, latches, tri-state driver and counter.
// TESTING
//  1. Reset mid-access:
//     - Stimulus: assert reset during the second ACCESS cycle of a write.
//     - Required response: readM/writeM drop the same cycle, data=Z, no ack, num_access=0.
//  2. Single read, MEM_LAT=2:
//     - Stimulus: ch0 reads 0x0010 from a memory holding 0xBEEF.
//     - Required response: readM=1 and address=0x0010 in cycles 1-2, ch_ack=01 in cycle 3, ch_rdata=0xBEEF, num_access=1.
//  3. Single write:
//     - Stimulus: ch1 writes 0x1234 to 0x0020.
//     - Required response: writeM=1 with data=0x1234 for 2 cycles, then data=Z and ch_ack=10.
//     - Check: a read-back via ch0 returns 0x1234.
//  4. Simultaneous requests:
//     - Stimulus: ch0 and ch1 request continuously from reset for 4 accesses each.
//     - Required response: grant order 0,1,0,1,...; each ack is 4 cycles after the previous one.
//  5. Input change after grant:
//     - Stimulus: change ch_addr/ch_wdata one cycle after grant.
//     - Required response: memory sees the originally latched values.
//  6. Counter wrap:
//     - Stimulus: CNT_W=4, perform 17 accesses.
//     - Required response: num_access=1; ch_rdata is unchanged across writes.

Source files
------------

// File: rtl/mem_bus_unit_pkg.sv
// Shared definitions for the memory bus unit: default sizes, FSM encoding, width helper.
package mem_bus_unit_pkg;

    localparam int unsigned MBU_WORD_SIZE       = 16;
    localparam int unsigned MBU_DEFAULT_MEM_LAT = 2;

    typedef enum logic [1:0] {
        MBU_IDLE   = 2'd0,
        MBU_ACCESS = 2'd1,
        MBU_DONE   = 2'd2
    } mbu_state_e;

    // Index width for n items; a single item still needs a one-bit index.
    function automatic int unsigned mbu_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_unit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module mem_bus_unit_rr_arbiter
    import mem_bus_unit_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = mbu_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant_c,
    output logic [IDX_W-1:0]  grant_idx_c,
    output logic              found_c
);

    // Scan channels starting at the pointer, wrapping once; the first hit wins.
    always_comb begin
        int unsigned idx;
        grant_c     = '0;
        grant_idx_c = '0;
        found_c     = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found_c && req[IDX_W'(idx)]) begin
                found_c                = 1'b1;
                grant_c[IDX_W'(idx)]   = 1'b1;
                grant_idx_c            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_bus_unit.sv
// Memory bus unit: round-robin arbitration of NUM_CH requesters onto one
// fixed-latency memory port, with a completed-access counter.
module mem_bus_unit
    import mem_bus_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = MBU_WORD_SIZE,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MEM_LAT   = MBU_DEFAULT_MEM_LAT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_req,
    input  logic [NUM_CH-1:0]             ch_we,
    input  logic [NUM_CH*WORD_SIZE-1:0]   ch_addr,
    input  logic [NUM_CH*WORD_SIZE-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]             ch_ack,
    output logic [WORD_SIZE-1:0]          ch_rdata,
    output logic                          readM,
    output logic                          writeM,
    output logic [WORD_SIZE-1:0]          address,
    inout  wire  [WORD_SIZE-1:0]          data,
    output logic                          busy,
    output logic [CNT_W-1:0]              num_access
);

    localparam int unsigned        IDX_W    = mbu_idx_w(NUM_CH);
    localparam int unsigned        LAT_W    = mbu_idx_w(MEM_LAT);
    localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_CH - 1);

    mbu_state_e           state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    logic [NUM_CH-1:0]    grant_c;
    logic [IDX_W-1:0]     grant_idx_c;
    logic                 found_c;
    logic                 grant_go_c;
    logic                 access_end_c;
    logic                 sel_we_c;
    logic [WORD_SIZE-1:0] sel_addr_c;
    logic [WORD_SIZE-1:0] sel_wdata_c;
    logic                 nxt_we_c;
    logic [WORD_SIZE-1:0] nxt_addr_c;

    logic [NUM_CH-1:0]    ack_d;
    logic                 read_d;
    logic                 write_d;
    logic                 busy_d;
    logic [WORD_SIZE-1:0] address_d;

    mem_bus_unit_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req         (ch_req),
        .ptr         (ptr_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .found_c     (found_c)
    );

    assign grant_go_c   = (state_q == MBU_IDLE) && found_c;
    assign access_end_c = (state_q == MBU_ACCESS) && (lat_q == LAT_LAST);

    // Pick the granted channel's command fields from the packed input buses.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_c[i]) begin
                sel_we_c    = ch_we[i];
                sel_addr_c  = ch_addr[i*WORD_SIZE +: WORD_SIZE];
                sel_wdata_c = ch_wdata[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MBU_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Next state: IDLE grants, ACCESS holds for MEM_LAT cycles, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            MBU_IDLE: begin
                if (found_c) begin
                    state_d = MBU_ACCESS;
                    lat_d   = '0;
                end
            end
            MBU_ACCESS: begin
                if (lat_q == LAT_LAST) begin
                    state_d = MBU_DONE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            MBU_DONE: begin
                state_d = MBU_IDLE;
            end
            default: begin
                state_d = MBU_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, so strobes line up with the state they belong to.
    always_comb begin
        nxt_we_c   = grant_go_c ? sel_we_c : we_q;
        nxt_addr_c = grant_go_c ? sel_addr_c : addr_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        address_d  = address;
        ack_d      = '0;
        busy_d     = (state_d != MBU_IDLE);
        if (state_d == MBU_ACCESS) begin
            read_d    = ~nxt_we_c;
            write_d   = nxt_we_c;
            address_d = nxt_addr_c;
        end
        if (state_d == MBU_DONE) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ack_d[i] = (gnt_idx_q == IDX_W'(i));
            end
        end
    end

    // Command latches at grant time and round-robin pointer advance on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            if (grant_go_c) begin
                gnt_idx_q <= grant_idx_c;
                we_q      <= sel_we_c;
                addr_q    <= sel_addr_c;
                wdata_q   <= sel_wdata_c;
            end
            if (state_q == MBU_DONE) begin
                ptr_q <= (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + IDX_W'(1);
            end
        end
    end

    // Registered outputs, read-data capture on the last ACCESS edge, access counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readM      <= 1'b0;
            writeM     <= 1'b0;
            address    <= '0;
            ch_ack     <= '0;
            busy       <= 1'b0;
            ch_rdata   <= '0;
            num_access <= '0;
        end else begin
            readM   <= read_d;
            writeM  <= write_d;
            address <= address_d;
            ch_ack  <= ack_d;
            busy    <= busy_d;
            if (access_end_c && !we_q) begin
                ch_rdata <= data;
            end
            if (state_q == MBU_DONE) begin
                num_access <= num_access + CNT_W'(1);
            end
        end
    end

    // The bus is driven only while a write strobe is out.
    assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: directed cases plus randomized two-channel traffic.
module tb_mem_bus_unit;

    localparam int NCH = 2;
    localparam int LAT = 2;
    localparam int NRAND = 60;
    localparam logic [15:0] IDLE_PAT = 16'hC3C3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_req;
    logic [1:0]  ch_we;
    logic [31:0] ch_addr;
    logic [31:0] ch_wdata;
    logic [1:0]  ch_ack;
    logic [15:0] ch_rdata;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    wire  [15:0] data;
    logic        busy;
    logic [3:0]  num_access;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [15:0] mem [0:255];

    mem_bus_unit #(
        .WORD_SIZE (16),
        .NUM_CH    (NCH),
        .MEM_LAT   (LAT),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_req     (ch_req),
        .ch_we      (ch_we),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_ack     (ch_ack),
        .ch_rdata   (ch_rdata),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data),
        .busy       (busy),
        .num_access (num_access)
    );

    always #5 clk = ~clk;

    // Memory drives read data; otherwise a marker pattern shows that nothing else drives the bus.
    assign data = (readM || !writeM) ? (readM ? mem[address[7:0]] : IDLE_PAT) : 16'hzzzz;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 257) ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // External memory
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        mem[8'h10] = 16'hBEEF;
        forever begin
            @(posedge clk);
            if (writeM) mem[address[7:0]] <= data;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [15:0] ref_mem [0:255];
        int          strobe_cnt;
        logic [15:0] bus_addr;
        logic [15:0] bus_wd;
        logic        bus_we;
        int          acc_model;
        logic [15:0] last_rd;
        int          wait_cnt [2];
        exp_t        e;
        int          c;
        logic        have;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_mem[8'h10] = 16'hBEEF;
        strobe_cnt = 0; acc_model = 0; last_rd = 16'h0;
        bus_addr = 16'h0; bus_wd = 16'h0; bus_we = 1'b0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                strobe_cnt = 0; acc_model = 0; last_rd = 16'h0;
                wait_cnt[0] = 0; wait_cnt[1] = 0;
                q0.delete(); q1.delete();
            end else begin
                check("strobe_excl", 32'(readM & writeM), 0);
                if (!readM && !writeM) check("bus_idle", 32'(data), 32'(IDLE_PAT));
                if (readM || writeM) begin
                    if (strobe_cnt == 0) begin
                        bus_addr = address; bus_we = writeM; bus_wd = data;
                    end else begin
                        check("addr_stable", 32'(address), 32'(bus_addr));
                        if (writeM) check("wdata_stable", 32'(data), 32'(bus_wd));
                    end
                    strobe_cnt++;
                end
                if (ch_ack != 2'b00) begin
                    check("ack_onehot", 32'($onehot(ch_ack)), 1);
                    c = ch_ack[1] ? 1 : 0;
                    have = (c == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    check("ack_expected", 32'(have), 1);
                    if (have) begin
                        e = (c == 0) ? q0.pop_front() : q1.pop_front();
                        check("acc_len", strobe_cnt, LAT);
                        check("acc_dir", 32'(bus_we), 32'(e.we));
                        check("acc_addr", 32'(bus_addr), 32'(e.addr));
                        if (e.we) begin
                            check("acc_wdata", 32'(bus_wd), 32'(e.wdata));
                            ref_mem[e.addr[7:0]] = e.wdata;
                            check("rdata_hold", 32'(ch_rdata), 32'(last_rd));
                        end else begin
                            check("rdata", 32'(ch_rdata), 32'(ref_mem[e.addr[7:0]]));
                            last_rd = ref_mem[e.addr[7:0]];
                        end
                    end
                    check("num_access", 32'(num_access), 32'(acc_model % 16));
                    acc_model++;
                    check("rr_wait", 32'(wait_cnt[c] <= NCH - 1), 1);
                    wait_cnt[c] = 0;
                    if (ch_req[1 - c]) wait_cnt[1 - c]++;
                    strobe_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input int c, input logic we, input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        ch_we[c] = we;
        ch_addr[c*16 +: 16] = a;
        ch_wdata[c*16 +: 16] = wd;
        ch_req[c] = 1'b1;
        e.we = we; e.addr = a; e.wdata = wd;
        if (c == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic wait_ack_drop(input int c);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ch_ack[c]) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 1);
        @(posedge clk); #1;
        ch_req[c] = 1'b0;
    endtask

    task automatic one_access(input int c, input logic we, input logic [15:0] a, input logic [15:0] wd);
        @(posedge clk); #1;
        issue(c, we, a, wd);
        wait_ack_drop(c);
    endtask

    // Cycle-exact single access from an idle unit.
    task automatic access_exact(input int c, input logic we, input logic [15:0] a, input logic [15:0] wd);
        @(posedge clk); #1;
        issue(c, we, a, wd);
        @(negedge clk);
        check("ex_c0_nostrobe", 32'(readM | writeM), 0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("ex_readM", 32'(readM), 32'(!we));
            check("ex_writeM", 32'(writeM), 32'(we));
            check("ex_address", 32'(address), 32'(a));
            if (we) check("ex_bus_wdata", 32'(data), 32'(wd));
        end
        @(negedge clk);
        check("ex_ack", 32'(ch_ack), 32'(1 << c));
        check("ex_bus_release", 32'(data), 32'(IDLE_PAT));
        @(posedge clk); #1;
        ch_req[c] = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ch_req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        logic [1:0] a;
        logic [1:0] pend;
        int issued, done_n, acks, last_cyc, exp_ch, c;
        int sent [2];

        reset = 1'b0; ch_req = 2'b00; ch_we = 2'b00; ch_addr = 32'h0; ch_wdata = 32'h0;
        #2 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_readM", 32'(readM), 0);
        check("rst_writeM", 32'(writeM), 0);
        check("rst_ack", 32'(ch_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_num_access", 32'(num_access), 0);
        check("rst_address", 32'(address), 0);
        check("rst_rdata", 32'(ch_rdata), 0);
        check("rst_bus", 32'(data), 32'(IDLE_PAT));
        @(posedge clk); #1; reset = 1'b0;

        // Reset during the second ACCESS cycle of a write
        @(posedge clk); #1;
        ch_we[0] = 1'b1; ch_addr[15:0] = 16'h00F0; ch_wdata[15:0] = 16'hDEAD; ch_req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t1_writeM_before", 32'(writeM), 1);
        check("t1_busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("t1_readM", 32'(readM), 0);
        check("t1_writeM", 32'(writeM), 0);
        check("t1_bus", 32'(data), 32'(IDLE_PAT));
        check("t1_ack", 32'(ch_ack), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_num_access", 32'(num_access), 0);
        ch_req = 2'b00;
        @(posedge clk); #1; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_no_ack", 32'(ch_ack), 0);
        end

        // Single read
        access_exact(0, 1'b0, 16'h0010, 16'h0000);
        check("t2_rdata", 32'(ch_rdata), 32'h0000BEEF);
        @(negedge clk);
        check("t2_num_access", 32'(num_access), 1);

        // Single write then read-back
        access_exact(1, 1'b1, 16'h0020, 16'h1234);
        access_exact(0, 1'b0, 16'h0020, 16'h0000);
        check("t3_readback", 32'(ch_rdata), 32'h00001234);

        // Inputs change after grant
        @(posedge clk); #1;
        issue(0, 1'b1, 16'h0030, 16'h5A5A);
        @(posedge clk); #1;
        ch_addr[15:0] = 16'h0031; ch_wdata[15:0] = 16'hFFFF; ch_we[0] = 1'b0;
        wait_ack_drop(0);
        check("t5_mem_written", 32'(mem[8'h30]), 32'h00005A5A);
        check("t5_mem_untouched", 32'(mem[8'h31]), 32'(init_val(8'h31)));
        one_access(1, 1'b0, 16'h0030, 16'h0000);

        // Randomized two-channel traffic
        pend = 2'b00; issued = 0; done_n = 0;
        for (int cyc = 0; cyc < 3000 && done_n < NRAND; cyc++) begin
            @(negedge clk); a = ch_ack;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (pend[k] && a[k]) begin
                    pend[k] = 1'b0; ch_req[k] = 1'b0; done_n++;
                end
                if (!pend[k] && issued < NRAND && $urandom_range(0, 3) != 0) begin
                    issue(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 47)), 16'($urandom));
                    pend[k] = 1'b1; issued++;
                end
            end
        end
        check("rand_all_acked", done_n, NRAND);

        // Continuous simultaneous requests from reset
        apply_reset();
        sent[0] = 0; sent[1] = 0;
        issue(0, 1'b0, 16'($urandom_range(0, 47)), 16'h0);
        issue(1, 1'b1, 16'($urandom_range(0, 47)), 16'($urandom));
        acks = 0; last_cyc = 0; exp_ch = 0;
        for (int cyc = 0; cyc < 200 && acks < 8; cyc++) begin
            @(negedge clk); a = ch_ack;
            if (a != 2'b00) begin
                check("t4_rr_order", 32'(a), 32'(1 << exp_ch));
                if (acks > 0) check("t4_ack_spacing", cyc - last_cyc, LAT + 2);
                last_cyc = cyc; acks++; exp_ch = 1 - exp_ch;
            end
            @(posedge clk); #1;
            if (a != 2'b00) begin
                c = a[1] ? 1 : 0;
                sent[c]++;
                if (sent[c] < 4) issue(c, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 47)), 16'($urandom));
                else ch_req[c] = 1'b0;
            end
        end
        check("t4_acks", acks, 8);

        // Counter wrap with 4-bit counter; reads hold across writes
        apply_reset();
        one_access(0, 1'b0, 16'h0040, 16'h0000);
        check("t6_first_read", 32'(ch_rdata), 32'(init_val(8'h40)));
        for (int k = 0; k < 15; k++) begin
            one_access(k % 2, 1'b1, 16'(16'h0041 + k), 16'(16'h7000 + k));
        end
        check("t6_rdata_hold", 32'(ch_rdata), 32'(init_val(8'h40)));
        one_access(1, 1'b0, 16'h0041, 16'h0000);
        check("t6_last_read", 32'(ch_rdata), 32'h00007000);
        @(negedge clk);
        check("t6_wrap", 32'(num_access), 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
